// File: rtl/keypad_pkg.sv
// Shared types, sizes and the Pmod KYPD key map for the keypad scanner.
package keypad_pkg;

    localparam int unsigned NUM_ROWS   = 4;
    localparam int unsigned NUM_COLS   = 4;
    localparam int unsigned ROW_W      = $clog2(NUM_ROWS);
    localparam int unsigned COL_W      = $clog2(NUM_COLS);
    localparam int unsigned CODE_W     = 4;
    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned DIGITS_W   = NUM_DIGITS * CODE_W;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_t;

    // Hex legend printed on the keypad, indexed by row and column
    function automatic logic [CODE_W-1:0] key_map(input logic [ROW_W-1:0] row_idx,
                                                  input logic [COL_W-1:0] col_idx);
        logic [CODE_W-1:0] code;
        case ({row_idx, col_idx})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'h0;
            4'hD: code = 4'hF;
            4'hE: code = 4'hE;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    // Position of the (single) low bit in an active-low row vector
    function automatic logic [ROW_W-1:0] low_row_idx(input logic [NUM_ROWS-1:0] rows);
        logic [ROW_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < int'(NUM_ROWS); i++) begin
            if (!rows[i]) idx = ROW_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_if.sv
// Keypad matrix pins plus the decoded key stream toward the display path.
interface keypad_if;
    import keypad_pkg::*;

    logic [NUM_ROWS-1:0] row;
    logic [NUM_COLS-1:0] col;
    logic                key_valid;
    logic [CODE_W-1:0]   key_code;
    logic                key_held;
    logic [DIGITS_W-1:0] digits;

    modport master (
        input  row,
        output col, key_valid, key_code, key_held, digits
    );

    modport slave (
        output row,
        input  col, key_valid, key_code, key_held, digits
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer; resets to all-ones so idle pulled-up lines read inactive.
module sync_2ff #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning, debouncing 4x4 hex keypad reader with an 8-digit history register.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SETTLE_CYC   = 100,
    parameter int unsigned DEBOUNCE_CYC = 1000000
) (
    input  logic     clk,
    input  logic     reset,
    keypad_if.master kp
);
    localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int unsigned DEB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYC - 1);

    state_t              state, state_nxt;
    logic [COL_W-1:0]    col_idx, col_idx_nxt;
    logic [SET_W-1:0]    settle_cnt, settle_nxt;
    logic [DEB_W-1:0]    deb_cnt, deb_nxt;
    logic [NUM_ROWS-1:0] cap_row, cap_row_nxt;
    logic [COL_W-1:0]    cap_col, cap_col_nxt;
    logic [NUM_COLS-1:0] col_q;
    logic                valid_q, valid_nxt;
    logic [CODE_W-1:0]   code_q, code_nxt;
    logic                held_q, held_nxt;
    logic [DIGITS_W-1:0] digits_q, digits_nxt;

    logic [NUM_ROWS-1:0] rows_s;
    logic [NUM_ROWS-1:0] rows_low;
    logic                single_low;

    sync_2ff #(.WIDTH(NUM_ROWS)) u_row_sync (
        .clk   (clk),
        .reset (reset),
        .d     (kp.row),
        .q     (rows_s)
    );

    // Exactly one row pulled low; more than one is ghosting or a chord
    assign rows_low   = ~rows_s;
    assign single_low = (rows_low != '0) && ((rows_low & (rows_low - NUM_ROWS'(1))) == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= SCAN;
            col_idx    <= '0;
            settle_cnt <= '0;
            deb_cnt    <= '0;
            cap_row    <= '1;
            cap_col    <= '0;
            col_q      <= 4'b1110;
            valid_q    <= 1'b0;
            code_q     <= '0;
            held_q     <= 1'b0;
            digits_q   <= '0;
        end else begin
            state      <= state_nxt;
            col_idx    <= col_idx_nxt;
            settle_cnt <= settle_nxt;
            deb_cnt    <= deb_nxt;
            cap_row    <= cap_row_nxt;
            cap_col    <= cap_col_nxt;
            col_q      <= ~(NUM_COLS'(1) << col_idx_nxt);
            valid_q    <= valid_nxt;
            code_q     <= code_nxt;
            held_q     <= held_nxt;
            digits_q   <= digits_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        col_idx_nxt = col_idx;
        settle_nxt  = settle_cnt;
        deb_nxt     = deb_cnt;
        cap_row_nxt = cap_row;
        cap_col_nxt = cap_col;
        valid_nxt   = 1'b0;
        code_nxt    = code_q;
        held_nxt    = held_q;
        digits_nxt  = digits_q;

        case (state)
            SCAN: begin
                if (settle_cnt == SET_LAST) begin
                    settle_nxt = '0;
                    if (single_low) begin
                        cap_row_nxt = rows_s;
                        cap_col_nxt = col_idx;
                        deb_nxt     = '0;
                        state_nxt   = DEBOUNCE;
                    end else begin
                        col_idx_nxt = col_idx + COL_W'(1);
                    end
                end else begin
                    settle_nxt = settle_cnt + SET_W'(1);
                end
            end
            DEBOUNCE: begin
                if (rows_s != cap_row) begin
                    settle_nxt = '0;
                    deb_nxt    = '0;
                    state_nxt  = SCAN;
                end else if (deb_cnt == DEB_LAST) begin
                    valid_nxt  = 1'b1;
                    code_nxt   = key_map(low_row_idx(cap_row), cap_col);
                    digits_nxt = {digits_q[DIGITS_W-CODE_W-1:0], code_nxt};
                    held_nxt   = 1'b1;
                    deb_nxt    = '0;
                    state_nxt  = HELD;
                end else begin
                    deb_nxt = deb_cnt + DEB_W'(1);
                end
            end
            HELD: begin
                if (rows_s == '1) begin
                    deb_nxt   = '0;
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                if (rows_s != '1) begin
                    deb_nxt   = '0;
                    state_nxt = HELD;
                end else if (deb_cnt == DEB_LAST) begin
                    held_nxt    = 1'b0;
                    col_idx_nxt = col_idx + COL_W'(1);
                    settle_nxt  = '0;
                    deb_nxt     = '0;
                    state_nxt   = SCAN;
                end else begin
                    deb_nxt = deb_cnt + DEB_W'(1);
                end
            end
            default: state_nxt = SCAN;
        endcase
    end

    assign kp.col       = col_q;
    assign kp.key_valid = valid_q;
    assign kp.key_code  = code_q;
    assign kp.key_held  = held_q;
    assign kp.digits    = digits_q;

endmodule
